mp_sram_arb: RTL and testbench

//   Parametrised multi-port SRAM: NPORT valid/ready request channels share one single-port

---
 rtl/mp_sram_arb_pkg.sv | 17 +
 rtl/mp_sram_arb_rr_arbiter.sv | 40 ++++
 rtl/mp_sram_arb.sv | 112 +++++++++++
 tb/tb_mp_sram_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_sram_arb_pkg.sv
// mp_sram_arb_pkg: shared constants and width helpers for the multi-port SRAM arbiter
package mp_sram_arb_pkg;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction
    function automatic int bw(input int dwidth);
        return dwidth / 8;
    endfunction
endpackage

// File: rtl/mp_sram_arb_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts one past the last winner
module rr_arbiter
    import mp_sram_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int PW    = idx_width(NPORT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             accept,
    output logic [NPORT-1:0] grant
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] cand;
    logic          found;
    // first requester after ptr, wrapping modulo NPORT
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = PW'((int'(ptr) + k) % NPORT);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end
    // pointer remembers the last accepted port; reset value makes port 0 win first
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PW'(NPORT - 1);
        else if (accept)
            ptr <= idx;
    end
endmodule

// File: rtl/mp_sram_arb.sv
// mp_sram_arb: NPORT valid/ready channels sharing one single-port array; SRAM_OUTREG_EN adds an output register (L=2)
module mp_sram_arb
    import mp_sram_arb_pkg::*;
#(
    parameter int  AWIDTH = 12,
    parameter int  SIZE   = 4096,
    parameter int  DWIDTH = 32,
    parameter int  NPORT  = 2,
    localparam int BW     = bw(DWIDTH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NPORT-1:0]        REQ_VALID,
    output logic [NPORT-1:0]        REQ_READY,
    input  logic [NPORT-1:0]        REQ_WEN,
    input  logic [NPORT*AWIDTH-1:0] REQ_ADDR,
    input  logic [NPORT*BW-1:0]     REQ_BE,
    input  logic [NPORT*DWIDTH-1:0] REQ_DI,
    output logic [NPORT-1:0]        RSP_VALID,
    output logic [DWIDTH-1:0]       RSP_DOUT
);
    localparam int MW = idx_width(SIZE);
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH + 1)'(SIZE);

    logic [NPORT-1:0]  grant;
    logic              acc;
    logic              sel_wen;
    logic [AWIDTH-1:0] sel_addr;
    logic [BW-1:0]     sel_be;
    logic [DWIDTH-1:0] sel_di;
    logic              in_range;
    logic [MW-1:0]     row;
    logic              rd_acc;
    logic [NPORT-1:0]  v1;
    logic [DWIDTH-1:0] d1;
    logic [DWIDTH-1:0] mem [SIZE];

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .clk   (CLK),
        .rst   (RST),
        .req   (REQ_VALID),
        .accept(acc),
        .grant (grant)
    );

    // ready is the grant, suppressed during reset; steer the granted channel to the array
    always_comb begin
        REQ_READY = RST ? '0 : grant;
        acc       = |REQ_READY;
        sel_wen   = RD;
        sel_addr  = '0;
        sel_be    = '0;
        sel_di    = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant[i]) begin
                sel_wen  = REQ_WEN[i];
                sel_addr = REQ_ADDR[i*AWIDTH +: AWIDTH];
                sel_be   = REQ_BE[i*BW +: BW];
                sel_di   = REQ_DI[i*DWIDTH +: DWIDTH];
            end
        end
        in_range = {1'b0, sel_addr} < LIMIT;
        row      = sel_addr[MW-1:0];
        rd_acc   = acc && (sel_wen == RD);
    end

    // byte-merge write; out-of-range writes are dropped
    always_ff @(posedge CLK) begin
        if (acc && (sel_wen == WR) && in_range)
            for (int b = 0; b < BW; b++)
                if (sel_be[b])
                    mem[row][b*8 +: 8] <= sel_di[b*8 +: 8];
    end

    // first response stage: one-hot valid for one cycle, data held until the next read
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1 <= '0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc ? REQ_READY : '0;
            if (rd_acc)
                d1 <= in_range ? mem[row] : '0;
        end
    end

`ifdef SRAM_OUTREG_EN
    logic [NPORT-1:0]  v2;
    logic [DWIDTH-1:0] d2;
    // extra output register stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            v2 <= '0;
            d2 <= '0;
        end else begin
            v2 <= v1;
            d2 <= d1;
        end
    end
    // responses are silenced while reset is asserted
    always_comb begin
        RSP_VALID = RST ? '0 : v2;
        RSP_DOUT  = RST ? '0 : d2;
    end
`else
    // responses are silenced while reset is asserted
    always_comb begin
        RSP_VALID = RST ? '0 : v1;
        RSP_DOUT  = RST ? '0 : d1;
    end
`endif
endmodule

// File: tb/tb_mp_sram_arb.sv
// tb_mp_sram_arb: randomized scoreboard bench for mp_sram_arb against a behavioural memory model
module tb_mp_sram_arb;
    localparam int AW = 13;
    localparam int SZ = 4096;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int BW = DW / 8;
`ifdef SRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    REQ_VALID;
    logic [NP-1:0]    REQ_READY;
    logic [NP-1:0]    REQ_WEN;
    logic [NP*AW-1:0] REQ_ADDR;
    logic [NP*BW-1:0] REQ_BE;
    logic [NP*DW-1:0] REQ_DI;
    logic [NP-1:0]    RSP_VALID;
    logic [DW-1:0]    RSP_DOUT;

    always #5 clk = ~clk;

    mp_sram_arb #(.AWIDTH(AW), .SIZE(SZ), .DWIDTH(DW), .NPORT(NP)) dut (
        .CLK      (clk),
        .RST      (rst),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WEN  (REQ_WEN),
        .REQ_ADDR (REQ_ADDR),
        .REQ_BE   (REQ_BE),
        .REQ_DI   (REQ_DI),
        .RSP_VALID(RSP_VALID),
        .RSP_DOUT (RSP_DOUT)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        longint        due;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] mm [int];
    int            ptr = NP - 1;
    longint        cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] last = '0;
    logic [NP-1:0] taken;
    int            pool [21];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rd_model(input int a);
        return (a >= SZ) ? '0 : mm[a];
    endfunction

    // reference model: predicts the round-robin winner and tracks array contents
    logic [NP-1:0] eg;
    int            gi;
    int            ma;
    logic [DW-1:0] tmp;
    always @(negedge clk) begin
        if (rst) begin
            ptr = NP - 1;
            chk("ready_in_reset", 64'(REQ_READY), 64'd0);
        end else begin
            gi = -1;
            for (int k = 1; k <= NP; k++)
                if (gi < 0 && REQ_VALID[(ptr + k) % NP]) gi = (ptr + k) % NP;
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            chk("ready_grant", 64'(REQ_READY), 64'(eg));
            if (gi >= 0) begin
                ma = int'(REQ_ADDR[gi*AW +: AW]);
                if (REQ_WEN[gi])
                    q.push_back('{port: gi, data: rd_model(ma), due: cyc + L});
                else if (ma < SZ) begin
                    tmp = mm.exists(ma) ? mm[ma] : '0;
                    for (int b = 0; b < BW; b++)
                        if (REQ_BE[gi*BW + b]) tmp[b*8 +: 8] = REQ_DI[gi*DW + b*8 +: 8];
                    mm[ma] = tmp;
                end
                ptr = gi;
            end
        end
    end

    // monitor: pops the expected response when it falls due and checks output hold otherwise
    logic [NP-1:0] ev;
    always @(negedge clk) begin
        if (rst) begin
            chk("rsp_valid_in_reset", 64'(RSP_VALID), 64'd0);
            chk("rsp_dout_in_reset", 64'(RSP_DOUT), 64'd0);
            q.delete();
            last = '0;
        end else begin
            ev = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                ev[q[0].port] = 1'b1;
                last = q[0].data;
                void'(q.pop_front());
            end
            chk("rsp_valid", 64'(RSP_VALID), 64'(ev));
            chk("rsp_dout", 64'(RSP_DOUT), 64'(last));
        end
    end

    task automatic set_req(input int p, input logic wen, input int a, input logic [BW-1:0] be, input logic [DW-1:0] di);
        REQ_VALID[p]         = 1'b1;
        REQ_WEN[p]           = wen;
        REQ_ADDR[p*AW +: AW] = AW'(a);
        REQ_BE[p*BW +: BW]   = be;
        REQ_DI[p*DW +: DW]   = di;
    endtask

    task automatic step();
        @(negedge clk);
        taken = REQ_VALID & REQ_READY;
        @(posedge clk);
        #1;
        REQ_VALID = REQ_VALID & ~taken;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (|REQ_VALID && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (|REQ_VALID) begin
            failures++;
            $display("FAIL drain_%s: pending=%b required=0 after %0d cycles", name, REQ_VALID, n);
            REQ_VALID = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        REQ_VALID = '0;
        REQ_WEN   = '0;
        REQ_ADDR  = '0;
        REQ_BE    = '0;
        REQ_DI    = '0;
        for (int i = 0; i < 16; i++) pool[i] = i;
        pool[16] = 904;
        pool[17] = 4095;
        pool[18] = 4096;
        pool[19] = 5000;
        pool[20] = 8191;
        // reset with every channel requesting
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 0, '1, '0);
        idle(4);
        REQ_VALID = '0;
        rst = 1'b0;
        // give every in-range address in the pool a known value
        for (int i = 0; i < 18; i++) begin
            set_req(0, 1'b0, pool[i], '1, rnd_data());
            drain("init");
        end
        // byte-enable merge
        set_req(1, 1'b0, 5, 4'hF, DW'(32'hAABBCCDD));
        drain("bw_full");
        set_req(1, 1'b0, 5, 4'b0101, DW'(32'h11223344));
        drain("bw_part");
        set_req(1, 1'b1, 5, '0, '0);
        drain("bw_read");
        idle(L + 1);
        // round-robin with both channels continuously requesting
        set_req(0, 1'b1, 1, '0, '0);
        set_req(1, 1'b1, 2, '0, '0);
        repeat (4) begin
            step();
            if (!REQ_VALID[0]) set_req(0, 1'b1, 1, '0, '0);
            if (!REQ_VALID[1]) set_req(1, 1'b1, 2, '0, '0);
        end
        drain("rr");
        idle(L + 1);
        // read-after-write on consecutive cycles
        set_req(0, 1'b0, 7, '1, DW'(32'h12345678));
        step();
        set_req(1, 1'b1, 7, '0, '0);
        drain("raw");
        idle(L + 1);
        // out-of-range write aliases nothing and reads back zero
        set_req(0, 1'b0, 5000, '1, rnd_data());
        drain("oor_wr");
        set_req(0, 1'b1, 5000, '0, '0);
        drain("oor_rd");
        set_req(1, 1'b1, 904, '0, '0);
        drain("alias_rd");
        idle(L + 1);
        // reset right after a read accept kills the response but keeps the array
        set_req(1, 1'b1, 7, '0, '0);
        step();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        set_req(0, 1'b1, 7, '0, '0);
        drain("post_rst");
        idle(L + 1);
        // random traffic with occasional drops and resets
        repeat (600) begin
            step();
            rst = ($urandom_range(99) < 2);
            for (int p = 0; p < NP; p++) begin
                if (REQ_VALID[p] && $urandom_range(19) == 0)
                    REQ_VALID[p] = 1'b0;
                else if (!REQ_VALID[p] && $urandom_range(1) == 1)
                    set_req(p, 1'($urandom_range(1)), pool[$urandom_range(20)], BW'($urandom()), rnd_data());
            end
        end
        rst = 1'b0;
        drain("final");
        idle(L + 2);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
